// File: rtl/max_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | max_scan_pkg : shared state encoding and defaults for max_scan_ctrl   |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package max_scan_pkg;

  localparam logic [31:0] DEF_RES_ADDR = 32'd2000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WR_VAL = 3'd2;
  localparam logic [2:0] ST_WR_IDX = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/max_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | max_scan_ctrl_if : data-memory port (combinational read, sync write)  |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
interface max_scan_ctrl_if;
  logic [31:0] mem_adr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  modport master (
    output mem_adr, mem_din, mem_read, mem_write,
    input  mem_dout
  );

  modport slave (
    input  mem_adr, mem_din, mem_read, mem_write,
    output mem_dout
  );
endinterface
`default_nettype wire

// File: rtl/max_scan_ctrl_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | max_cmp : combinational a > b, signed or unsigned by parameter        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module max_cmp #(
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  generate
    if (SIGNED_CMP) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/max_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | max_scan_ctrl : scans LEN words for the maximum, writes value + index |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module max_scan_ctrl
  import max_scan_pkg::*;
#(
  parameter logic [31:0] RES_ADDR   = DEF_RES_ADDR,
  parameter bit          SIGNED_CMP = 1'b1,
  parameter int          LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      max_value,
  output logic [31:0]      max_index,
  max_scan_ctrl_if.master  mem
);

  logic [2:0]       r_state;
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_last;
  logic             r_err;
  logic [31:0]      r_max_value;
  logic [31:0]      r_max_index;
  logic             w_gt;

  max_cmp #(.SIGNED_CMP(SIGNED_CMP)) u_cmp (
    .a      (mem.mem_dout),
    .b      (r_max_value),
    .a_gt_b (w_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_err       <= 1'b0;
      r_max_value <= '0;
      r_max_index <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr  <= word_align(base_addr);
            r_idx   <= '0;
            r_last  <= len - 1'b1;
            r_err   <= (len == '0);
            r_state <= (len == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          // Element 0 seeds the result; later elements must be strictly larger
          if ((r_idx == '0) || w_gt) begin
            r_max_value <= mem.mem_dout;
            r_max_index <= 32'(r_idx);
          end
          if (r_idx == r_last) begin
            r_state <= ST_WR_VAL;
          end else begin
            r_idx  <= r_idx + 1'b1;
            r_addr <= r_addr + 32'd4;
          end
        end
        ST_WR_VAL: r_state <= ST_WR_IDX;
        ST_WR_IDX: r_state <= ST_DONE;
        ST_DONE:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem.mem_adr   = '0;
    mem.mem_din   = '0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    case (r_state)
      ST_READ: begin
        mem.mem_adr  = r_addr;
        mem.mem_read = 1'b1;
      end
      ST_WR_VAL: begin
        mem.mem_adr   = RES_ADDR;
        mem.mem_din   = r_max_value;
        mem.mem_write = 1'b1;
      end
      ST_WR_IDX: begin
        mem.mem_adr   = RES_ADDR + 32'd4;
        mem.mem_din   = r_max_index;
        mem.mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign max_value = r_max_value;
  assign max_index = r_max_index;

endmodule
`default_nettype wire

// File: tb/tb_max_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_max_scan_ctrl : signed and unsigned instances share one stimulus   |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_max_scan_ctrl;
  localparam int LEN_W = 16;
  localparam int MEMW  = 1024;
  localparam logic [31:0] SENT_V = 32'hDEAD_BEEF;
  localparam logic [31:0] SENT_I = 32'hDEAD_BEE4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [LEN_W-1:0] len = '0;

  logic        busy_s, done_s, err_s, busy_u, done_u, err_u;
  logic [31:0] mv_s, mi_s, mv_u, mi_u;

  max_scan_ctrl_if mif_s ();
  max_scan_ctrl_if mif_u ();

  max_scan_ctrl #(.RES_ADDR(32'd2000), .SIGNED_CMP(1'b1), .LEN_W(LEN_W)) dut_s (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy_s), .done(done_s), .err(err_s), .max_value(mv_s), .max_index(mi_s),
    .mem(mif_s)
  );

  max_scan_ctrl #(.RES_ADDR(32'd2000), .SIGNED_CMP(1'b0), .LEN_W(LEN_W)) dut_u (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy_u), .done(done_u), .err(err_u), .max_value(mv_u), .max_index(mi_u),
    .mem(mif_u)
  );

  always #5 clk = ~clk;

  // Word-addressed memories, one per instance; the tb preloads through ld_*
  logic [31:0] mem_s [MEMW];
  logic [31:0] mem_u [MEMW];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_a  = '0;
  logic [31:0] ld_d  = '0;

  assign mif_s.mem_dout = mem_s[mif_s.mem_adr[11:2]];
  assign mif_u.mem_dout = mem_u[mif_u.mem_adr[11:2]];

  logic [31:0] rd_log[$];
  int unsigned wr_cnt_s = 0;
  int unsigned wr_cnt_u = 0;

  always @(posedge clk) begin
    if (ld_en) begin
      mem_s[ld_a] <= ld_d;
      mem_u[ld_a] <= ld_d;
    end
    if (mif_s.mem_write) begin
      mem_s[mif_s.mem_adr[11:2]] <= mif_s.mem_din;
      wr_cnt_s <= wr_cnt_s + 1;
    end
    if (mif_u.mem_write) begin
      mem_u[mif_u.mem_adr[11:2]] <= mif_u.mem_din;
      wr_cnt_u <= wr_cnt_u + 1;
    end
    if (mif_s.mem_read) rd_log.push_back(mif_s.mem_adr);
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int unsigned w, input logic [31:0] d);
    ld_en = 1'b1;
    ld_a  = w[9:0];
    ld_d  = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic kick(input logic [31:0] b, input int unsigned l);
    base_addr = b;
    len       = l[LEN_W-1:0];
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (done_s !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done_s !== 1'b1) chk("done_timeout", 32'(done_s), 32'd1);
  endtask

  // Reference: maximum over the value set, then the first position holding it
  function automatic void ref_max(input logic [31:0] q[$], input bit sgn,
                                  output logic [31:0] v, output logic [31:0] ix);
    longint key[$];
    longint best;
    foreach (q[k]) key.push_back(sgn ? longint'($signed(q[k])) : longint'({32'd0, q[k]}));
    best = key[0];
    foreach (key[k]) if (key[k] > best) best = key[k];
    ix = 0;
    for (int k = q.size() - 1; k >= 0; k--) if (key[k] == best) ix = 32'(k);
    v = q[ix];
  endfunction

  task automatic do_run(input string tag, input logic [31:0] b, input int unsigned l,
                        input logic [31:0] q[$], input logic [31:0] vs, input logic [31:0] is,
                        input logic [31:0] vu, input logic [31:0] iu, input logic e);
    int          cyc;
    int unsigned rd0, ws0, wu0;
    logic [31:0] wb;
    wb = b & ~32'd3;
    for (int k = 0; k < int'(l); k++) load((wb >> 2) + k, q[k]);
    load(500, SENT_V);
    load(501, SENT_I);
    rd0 = rd_log.size();
    ws0 = wr_cnt_s;
    wu0 = wr_cnt_u;
    kick(b, l);
    cyc = 1;
    wait_done(cyc);
    chk($sformatf("%s.cycles", tag), 32'(cyc), (l == 0) ? 32'd1 : 32'(l + 3));
    chk($sformatf("%s.busy_at_done", tag), 32'(busy_s), 32'd1);
    chk($sformatf("%s.done_u", tag), 32'(done_u), 32'd1);
    chk($sformatf("%s.err_s", tag), 32'(err_s), 32'(e));
    chk($sformatf("%s.err_u", tag), 32'(err_u), 32'(e));
    if (!e) begin
      chk($sformatf("%s.value_s", tag), mv_s, vs);
      chk($sformatf("%s.index_s", tag), mi_s, is);
      chk($sformatf("%s.value_u", tag), mv_u, vu);
      chk($sformatf("%s.index_u", tag), mi_u, iu);
    end
    @(posedge clk); #1;
    chk($sformatf("%s.busy_after", tag), 32'(busy_s), 32'd0);
    chk($sformatf("%s.done_after", tag), 32'(done_s), 32'd0);
    if (!e) begin
      chk($sformatf("%s.mem500_s", tag), mem_s[500], vs);
      chk($sformatf("%s.mem501_s", tag), mem_s[501], is);
      chk($sformatf("%s.mem500_u", tag), mem_u[500], vu);
      chk($sformatf("%s.mem501_u", tag), mem_u[501], iu);
      chk($sformatf("%s.writes_s", tag), 32'(wr_cnt_s - ws0), 32'd2);
    end else begin
      chk($sformatf("%s.mem500_kept", tag), mem_s[500], SENT_V);
      chk($sformatf("%s.mem501_kept", tag), mem_s[501], SENT_I);
      chk($sformatf("%s.writes_s", tag), 32'(wr_cnt_s - ws0), 32'd0);
      chk($sformatf("%s.writes_u", tag), 32'(wr_cnt_u - wu0), 32'd0);
    end
    chk($sformatf("%s.reads", tag), 32'(rd_log.size() - rd0), 32'(l));
    if (rd_log.size() == rd0 + l)
      for (int k = 0; k < int'(l); k++)
        chk($sformatf("%s.rd_adr%0d", tag, k), rd_log[rd0 + k], wb + 32'(4 * k));
  endtask

  typedef struct packed {
    logic [31:0]      base;
    logic [15:0]      len;
    logic [4:0][31:0] d;
    logic [31:0]      vs, is, vu, iu;
    logic             err;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] b, input logic [15:0] l,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input logic [31:0] w4,
                              input logic [31:0] vs, input logic [31:0] is,
                              input logic [31:0] vu, input logic [31:0] iu, input logic e);
    vec_t v;
    v.base = b; v.len = l;
    v.d[0] = w0; v.d[1] = w1; v.d[2] = w2; v.d[3] = w3; v.d[4] = w4;
    v.vs = vs; v.is = is; v.vu = vu; v.iu = iu; v.err = e;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    logic [31:0] q[$];
    logic [31:0] vs, is, vu, iu, b;
    int unsigned l;
    int          cyc;
    int unsigned ws0, rd0;

    vecs[0] = mk(1000, 5, 5, 9, 3, 9, 1,                    9, 1, 9, 1, 0);
    vecs[1] = mk(1000, 3, -32'sd7, -32'sd2, -32'sd9, 0, 0,  32'hFFFF_FFFE, 1, 32'hFFFF_FFFE, 1, 0);
    vecs[2] = mk(1000, 2, 0, 32'hFFFF_FFFF, 0, 0, 0,        0, 0, 32'hFFFF_FFFF, 1, 0);
    vecs[3] = mk(1000, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 1);
    vecs[4] = mk(1003, 2, 7, 8, 0, 0, 0,                    8, 1, 8, 1, 0);
    vecs[5] = mk(200, 1, 32'h8000_0000, 0, 0, 0, 0,         32'h8000_0000, 0, 32'h8000_0000, 0, 0);
    vecs[6] = mk(40, 4, 3, 3, 3, 3, 0,                      3, 0, 3, 0, 0);
    vecs[7] = mk(600, 4, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h8000_0001, 0,
                 32'h7FFF_FFFF, 1, 32'h8000_0001, 3, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy_s), 0);
    chk("rst.done", 32'(done_s), 0);
    chk("rst.err", 32'(err_s), 0);
    chk("rst.value", mv_s, 0);
    chk("rst.index", mi_s, 0);
    chk("rst.mem_read", 32'(mif_s.mem_read), 0);
    chk("rst.mem_write", 32'(mif_s.mem_write), 0);
    chk("rst.mem_adr", mif_s.mem_adr, 0);
    chk("rst.mem_din", mif_s.mem_din, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      q.delete();
      for (int k = 0; k < int'(vecs[v].len); k++) q.push_back(vecs[v].d[k]);
      do_run($sformatf("vec%0d", v), vecs[v].base, int'(vecs[v].len), q,
             vecs[v].vs, vecs[v].is, vecs[v].vu, vecs[v].iu, vecs[v].err);
    end

    for (int r = 0; r < 40; r++) begin
      l = (r % 13 == 5) ? 0 : $urandom_range(1, 8);
      b = ($urandom_range(0, 470) << 2) | $urandom_range(0, 3);
      q.delete();
      for (int k = 0; k < int'(l); k++) begin
        case ($urandom_range(0, 3))
          0: q.push_back(32'($urandom_range(0, 15)));
          1: q.push_back($urandom);
          2: q.push_back(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
          default: q.push_back((k == 0) ? $urandom : q[$urandom_range(0, k - 1)]);
        endcase
      end
      vs = 0; is = 0; vu = 0; iu = 0;
      if (l != 0) begin
        ref_max(q, 1'b1, vs, is);
        ref_max(q, 1'b0, vu, iu);
      end
      do_run($sformatf("rnd%0d", r), b, l, q, vs, is, vu, iu, l == 0);
    end

    // A second start during the scan must not disturb the first request
    q = '{4, 10, 2, 6, 1};
    for (int k = 0; k < 5; k++) load(250 + k, q[k]);
    load(500, SENT_V);
    rd0 = rd_log.size();
    kick(1000, 5);
    cyc = 1;
    @(posedge clk); #1; cyc++;
    base_addr = 100; len = 2; start = 1'b1;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    wait_done(cyc);
    chk("midstart.cycles", 32'(cyc), 8);
    chk("midstart.value", mv_s, 10);
    chk("midstart.index", mi_s, 1);
    chk("midstart.reads", 32'(rd_log.size() - rd0), 5);
    @(posedge clk); #1;
    chk("midstart.mem500", mem_s[500], 10);

    // Reset in cycle 3 of a len=5 scan
    for (int k = 0; k < 5; k++) load(250 + k, 32'(k + 20));
    load(500, SENT_V);
    load(501, SENT_I);
    ws0 = wr_cnt_s;
    kick(1000, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.busy", 32'(busy_s), 0);
    chk("midrst.done", 32'(done_s), 0);
    chk("midrst.value", mv_s, 0);
    chk("midrst.index", mi_s, 0);
    chk("midrst.mem_read", 32'(mif_s.mem_read), 0);
    chk("midrst.mem_adr", mif_s.mem_adr, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst.writes", 32'(wr_cnt_s - ws0), 0);
    chk("midrst.mem500", mem_s[500], SENT_V);
    chk("midrst.mem501", mem_s[501], SENT_I);

    // Back-to-back: len=0 error run, then normal runs accepted right after done
    q = '{5, 9, 3, 9, 1};
    for (int k = 0; k < 5; k++) load(250 + k, q[k]);
    kick(1000, 0);
    cyc = 1;
    wait_done(cyc);
    chk("b2b.len0_cycles", 32'(cyc), 1);
    chk("b2b.len0_err", 32'(err_s), 1);
    @(posedge clk); #1;
    chk("b2b.err_held", 32'(err_s), 1);
    kick(1000, 5);
    chk("b2b.err_cleared", 32'(err_s), 0);
    chk("b2b.busy", 32'(busy_s), 1);
    cyc = 1;
    wait_done(cyc);
    chk("b2b.run1_cycles", 32'(cyc), 8);
    chk("b2b.run1_value", mv_s, 9);
    @(posedge clk); #1;
    chk("b2b.value_held", mv_s, 9);
    kick(1012, 2);
    cyc = 1;
    wait_done(cyc);
    chk("b2b.run2_cycles", 32'(cyc), 5);
    chk("b2b.run2_value", mv_s, 9);
    chk("b2b.run2_index", mi_s, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b.idle_value", mv_s, 9);
    chk("b2b.idle_index", mi_s, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
